// File: rtl/smallcpu_pkg.sv
// Shared constants and types for the small CPU program loader.
package smallcpu_pkg;

    localparam logic [7:0] CMD_WRITE = 8'hA5;
    localparam logic [7:0] CMD_READ  = 8'h5A;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        IGNORE
    } ld_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/smallcpu_pin_sync.sv
// N-stage pin synchroniser with single-cycle rise/fall pulses on the synced level.
module smallcpu_pin_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], pin};
            prev  <= chain[STAGES-1];
        end
    end

    assign sync = chain[STAGES-1];
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/smallcpu_prog_loader.sv
// Serial program loader: shifts command/address/words in from pins and writes CPU program memory.
// Optional readback over pin_miso is enabled by defining SMALLCPU_LOADER_READBACK_EN.
module smallcpu_prog_loader
    import smallcpu_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pin_sclk,
    input  logic              pin_cs_n,
    input  logic              pin_mosi,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              err,
    output logic [ADDR_W-1:0] words_loaded
`ifdef SMALLCPU_LOADER_READBACK_EN
    ,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              pin_miso
`endif
);

    localparam int SR_W  = max_int(DATA_W, max_int(ADDR_W, 8));
    localparam int CNT_W = $clog2(SR_W + 1);

    logic sclk_sync, sclk_rise, sclk_fall;
    logic cs_sync, cs_rise, cs_fall;
    logic mosi_sync, mosi_rise, mosi_fall;

    smallcpu_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .pin(pin_sclk),
        .sync(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
    );
    smallcpu_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .pin(pin_cs_n),
        .sync(cs_sync), .rise(cs_rise), .fall(cs_fall)
    );
    smallcpu_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .pin(pin_mosi),
        .sync(mosi_sync), .rise(mosi_rise), .fall(mosi_fall)
    );

    ld_state_e            state, state_nxt;
    logic [SR_W-1:0]      sr, sh_val;
    logic [CNT_W-1:0]     bit_cnt, last_idx;
    logic [ADDR_W-1:0]    addr_reg;
    logic                 bit_last, sh_en, cmd_ok, is_read, rd_mode, armed;
    logic [SYNC_STAGES:0] fill_pipe;
    logic                 unused;

`ifdef SMALLCPU_LOADER_READBACK_EN
    localparam int RB_W = $clog2(DATA_W);
    logic [DATA_W-1:0] out_sr, pf_word, cur_word;
    logic [RB_W-1:0]   rbit;
    logic [1:0]        rd_lat;
    logic              first_ld;

    // Until the first word lands in out_sr, the earliest fall reads straight from memory.
    assign cur_word = first_ld ? mem_rdata : out_sr;
`endif

    assign cpu_hold = (state != IDLE);
    assign unused   = ^{sclk_sync, sclk_fall, mosi_rise, mosi_fall, sr[SR_W-1]};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        last_idx  = CNT_W'(DATA_W - 1);
        case (state)
            CMD:     last_idx = CNT_W'(7);
            ADDR:    last_idx = CNT_W'(ADDR_W - 1);
            default: ;
        endcase
        bit_last = (bit_cnt == last_idx);
        sh_val   = {sr[SR_W-2:0], mosi_sync};
        // cs_n release beats a simultaneous sclk edge; read frames do not shift mosi in DATA.
        sh_en    = sclk_rise && !cs_rise &&
                   ((state == CMD) || (state == ADDR) || (state == DATA && !rd_mode));
        is_read  = 1'b0;
`ifdef SMALLCPU_LOADER_READBACK_EN
        is_read  = (sh_val[7:0] == CMD_READ);
`endif
        cmd_ok   = (sh_val[7:0] == CMD_WRITE) || is_read;

        case (state)
            IDLE:    if (cs_fall && armed) state_nxt = CMD;
            CMD:     if (sh_en && bit_last) state_nxt = cmd_ok ? ADDR : IGNORE;
            ADDR:    if (sh_en && bit_last) state_nxt = DATA;
            default: ;
        endcase
        if (state != IDLE && cs_rise) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            err          <= 1'b0;
            words_loaded <= '0;
            addr_reg     <= '0;
            sr           <= '0;
            bit_cnt      <= '0;
            rd_mode      <= 1'b0;
            armed        <= 1'b0;
            fill_pipe    <= '0;
`ifdef SMALLCPU_LOADER_READBACK_EN
            pin_miso     <= 1'b0;
            out_sr       <= '0;
            pf_word      <= '0;
            rbit         <= '0;
            rd_lat       <= '0;
            first_ld     <= 1'b0;
`endif
        end else begin
            mem_we    <= 1'b0;
            // A frame already open when reset drops is ignored until cs_n is seen high.
            fill_pipe <= {fill_pipe[SYNC_STAGES-1:0], 1'b1};
            if (fill_pipe[SYNC_STAGES] && cs_sync) armed <= 1'b1;
`ifdef SMALLCPU_LOADER_READBACK_EN
            rd_lat    <= {rd_lat[0], 1'b0};
`endif

            if (mem_we) begin
                addr_reg <= addr_reg + ADDR_W'(1);
                if (words_loaded != '1) words_loaded <= words_loaded + ADDR_W'(1);
            end

            if (state == IDLE && state_nxt == CMD) begin
                err          <= 1'b0;
                words_loaded <= '0;
                sr           <= '0;
                bit_cnt      <= '0;
                rd_mode      <= 1'b0;
            end

            if (sh_en) begin
                sr      <= sh_val;
                bit_cnt <= bit_last ? '0 : bit_cnt + CNT_W'(1);
                if (bit_last) begin
                    case (state)
                        CMD: begin
                            if (!cmd_ok) err <= 1'b1;
                            rd_mode <= is_read;
                        end
                        ADDR: begin
                            addr_reg <= sh_val[ADDR_W-1:0];
`ifdef SMALLCPU_LOADER_READBACK_EN
                            if (rd_mode) begin
                                mem_addr  <= sh_val[ADDR_W-1:0];
                                rd_lat[0] <= 1'b1;
                                first_ld  <= 1'b1;
                                rbit      <= '0;
                            end
`endif
                        end
                        DATA: begin
                            mem_we    <= 1'b1;
                            mem_addr  <= addr_reg;
                            mem_wdata <= sh_val[DATA_W-1:0];
                        end
                        default: ;
                    endcase
                end
            end

`ifdef SMALLCPU_LOADER_READBACK_EN
            if (rd_mode && state == DATA) begin
                if (rd_lat[1]) begin
                    if (first_ld) begin
                        out_sr    <= mem_rdata;
                        first_ld  <= 1'b0;
                        mem_addr  <= mem_addr + ADDR_W'(1);
                        rd_lat[0] <= 1'b1;
                    end else begin
                        pf_word <= mem_rdata;
                    end
                end
                if (sclk_fall && !cs_rise) begin
                    pin_miso <= cur_word[DATA_W-1];
                    if (rbit == RB_W'(DATA_W - 1)) begin
                        rbit      <= '0;
                        out_sr    <= pf_word;
                        mem_addr  <= mem_addr + ADDR_W'(1);
                        rd_lat[0] <= 1'b1;
                    end else begin
                        rbit   <= rbit + RB_W'(1);
                        out_sr <= {cur_word[DATA_W-2:0], 1'b0};
                    end
                end
            end
`endif

            if (state != IDLE && state_nxt == IDLE) begin
                sr      <= '0;
                bit_cnt <= '0;
                rd_mode <= 1'b0;
`ifdef SMALLCPU_LOADER_READBACK_EN
                pin_miso <= 1'b0;
                first_ld <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_smallcpu_prog_loader.sv
// Directed bench for smallcpu_prog_loader: write, bad command, wrap, abort, reset, readback.
module tb_smallcpu_prog_loader;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int SS     = 2;
    localparam int H      = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              pin_sclk = 1'b0;
    logic              pin_cs_n = 1'b1;
    logic              pin_mosi = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_hold;
    logic              err;
    logic [ADDR_W-1:0] words_loaded;
`ifdef SMALLCPU_LOADER_READBACK_EN
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              pin_miso;
`endif

    int checks = 0;
    int fails  = 0;
    int hold_viol = 0;
    logic [ADDR_W-1:0] wa_q[$];
    logic [DATA_W-1:0] wd_q[$];
    logic [DATA_W-1:0] mem [256];

    smallcpu_prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst),
        .pin_sclk(pin_sclk), .pin_cs_n(pin_cs_n), .pin_mosi(pin_mosi),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .err(err), .words_loaded(words_loaded)
`ifdef SMALLCPU_LOADER_READBACK_EN
        , .mem_rdata(mem_rdata), .pin_miso(pin_miso)
`endif
    );

    always #5 clk = ~clk;

    // Program memory model: write log plus registered one-cycle read.
    always @(posedge clk) begin
        if (!rst && mem_we) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
            mem[mem_addr] = mem_wdata;
            if (!cpu_hold) hold_viol++;
        end
`ifdef SMALLCPU_LOADER_READBACK_EN
        mem_rdata <= mem[mem_addr];
`endif
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            pin_mosi = v[i];
            pin_sclk = 1'b0;
            cyc(H);
            pin_sclk = 1'b1;
            cyc(H);
        end
    endtask

    task automatic frame_start();
        pin_cs_n = 1'b0;
        cyc(4);
    endtask

    task automatic frame_end();
        pin_sclk = 1'b0;
        cyc(H);
        pin_cs_n = 1'b1;
        cyc(6);
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_we"},    {31'd0, mem_we},   32'd0);
        chk({tag, "_addr"},  {24'd0, mem_addr}, 32'd0);
        chk({tag, "_wdata"}, {16'd0, mem_wdata}, 32'd0);
        chk({tag, "_hold"},  {31'd0, cpu_hold}, 32'd0);
        chk({tag, "_err"},   {31'd0, err},      32'd0);
        chk({tag, "_words"}, {24'd0, words_loaded}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;

        // Reset state
        cyc(5);
        chk_outputs_zero("rst");
`ifdef SMALLCPU_LOADER_READBACK_EN
        chk("rst_miso", {31'd0, pin_miso}, 32'd0);
`endif
        rst = 1'b0;
        cyc(6);

        // Two-word write frame
        clear_log();
        frame_start();
        chk("wr_hold_in", {31'd0, cpu_hold}, 32'd1);
        send_bits(32'hA5, 8);
        send_bits(32'h03, 8);
        send_bits(32'h1234, 16);
        send_bits(32'hABCD, 16);
        chk("wr_hold_late", {31'd0, cpu_hold}, 32'd1);
        frame_end();
        chk("wr_n",     wa_q.size(), 2);
        chk("wr_a0",    {24'd0, wa_q[0]}, 32'h03);
        chk("wr_d0",    {16'd0, wd_q[0]}, 32'h1234);
        chk("wr_a1",    {24'd0, wa_q[1]}, 32'h04);
        chk("wr_d1",    {16'd0, wd_q[1]}, 32'hABCD);
        chk("wr_words", {24'd0, words_loaded}, 32'd2);
        chk("wr_err",   {31'd0, err}, 32'd0);
        chk("wr_hold",  {31'd0, cpu_hold}, 32'd0);

        // Bad command, sticky err
        clear_log();
        frame_start();
        send_bits(32'h3C, 8);
        chk("bad_err_now", {31'd0, err}, 32'd1);
        send_bits(32'hFF, 8);
        chk("bad_hold_in", {31'd0, cpu_hold}, 32'd1);
        frame_end();
        chk("bad_n",    wa_q.size(), 0);
        chk("bad_err",  {31'd0, err}, 32'd1);
        chk("bad_hold", {31'd0, cpu_hold}, 32'd0);

        // Valid frame clears err; address wraps FF -> 00
        frame_start();
        chk("wrap_err_clr", {31'd0, err}, 32'd0);
        send_bits(32'hA5, 8);
        send_bits(32'hFF, 8);
        send_bits(32'h0001, 16);
        send_bits(32'h0002, 16);
        frame_end();
        chk("wrap_n",  wa_q.size(), 2);
        chk("wrap_a0", {24'd0, wa_q[0]}, 32'hFF);
        chk("wrap_d0", {16'd0, wd_q[0]}, 32'h0001);
        chk("wrap_a1", {24'd0, wa_q[1]}, 32'h00);
        chk("wrap_d1", {16'd0, wd_q[1]}, 32'h0002);
        chk("wrap_words", {24'd0, words_loaded}, 32'd2);

        // Abort mid-word: partial word dropped, hold released promptly
        clear_log();
        frame_start();
        send_bits(32'hA5, 8);
        send_bits(32'h10, 8);
        send_bits(32'h155, 9);
        pin_sclk = 1'b0;
        cyc(H);
        pin_cs_n = 1'b1;
        cyc(SS + 1);
        chk("abort_hold", {31'd0, cpu_hold}, 32'd0);
        cyc(6);
        chk("abort_n",     wa_q.size(), 0);
        chk("abort_words", {24'd0, words_loaded}, 32'd0);

`ifdef SMALLCPU_LOADER_READBACK_EN
        // Readback of two consecutive words; no writes allowed
        clear_log();
        mem[8'h20] = 16'hBEEF;
        mem[8'h21] = 16'h1234;
        begin
            logic [DATA_W-1:0] w0, w1;
            w0 = '0;
            w1 = '0;
            frame_start();
            send_bits(32'h5A, 8);
            chk("rd_cmd_err", {31'd0, err}, 32'd0);
            send_bits(32'h20, 8);
            for (int i = 0; i < 2 * DATA_W; i++) begin
                pin_sclk = 1'b0;
                cyc(H);
                if (i < DATA_W) w0 = {w0[DATA_W-2:0], pin_miso};
                else            w1 = {w1[DATA_W-2:0], pin_miso};
                pin_sclk = 1'b1;
                cyc(H);
            end
            frame_end();
            chk("rd_w0", {16'd0, w0}, 32'hBEEF);
            chk("rd_w1", {16'd0, w1}, 32'h1234);
            chk("rd_nowr", wa_q.size(), 0);
            chk("rd_miso_idle", {31'd0, pin_miso}, 32'd0);
        end
`else
        // Read command is not supported in this build
        clear_log();
        frame_start();
        send_bits(32'h5A, 8);
        send_bits(32'h20, 8);
        frame_end();
        chk("rd_bad_err", {31'd0, err}, 32'd1);
        chk("rd_bad_n",   wa_q.size(), 0);
`endif

        // Reset in the 10th data bit, then a frame left open across reset release
        clear_log();
        frame_start();
        send_bits(32'hA5, 8);
        send_bits(32'h20, 8);
        send_bits(32'h1FF, 9);
        pin_mosi = 1'b1;
        pin_sclk = 1'b0;
        cyc(H);
        pin_sclk = 1'b1;
        cyc(1);
        rst = 1'b1;
        cyc(3);
        chk_outputs_zero("mid_rst");
        rst = 1'b0;
        send_bits(32'hA5, 8);
        send_bits(32'h30, 8);
        send_bits(32'h5555, 16);
        chk("stale_hold", {31'd0, cpu_hold}, 32'd0);
        frame_end();
        chk("stale_n", wa_q.size(), 0);
        frame_start();
        send_bits(32'hA5, 8);
        send_bits(32'h40, 8);
        send_bits(32'hCAFE, 16);
        frame_end();
        chk("post_n",  wa_q.size(), 1);
        chk("post_a",  {24'd0, wa_q[0]}, 32'h40);
        chk("post_d",  {16'd0, wd_q[0]}, 32'hCAFE);
        chk("post_words", {24'd0, words_loaded}, 32'd1);

        chk("we_hold", hold_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
